// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter/sequencer for the shared 8-bit ALU: accept, issue for one cycle, then respond.
// Optional saturating statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arb_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic             req1_cin,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_opcode,
    output logic             alu_en,
    input  logic [7:0]       alu_out,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_out,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_err,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] stat_ops0,
    output logic [CNT_W-1:0] stat_ops1,
    output logic [CNT_W-1:0] stat_err,
`endif
    output logic [1:0]       fsm_state
);

    // Debug encoding on fsm_state: 0 = IDLE, 1 = ISSUE, 2 = RESP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_id;
    logic   grant0, grant1, accept;
    logic   legal, arith;

    // Handshakes (all channels): a transfer happens in a cycle where valid && ready are both high;
    // ready never depends on anything but state, the valids and the round-robin pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_id;
            grant1 = !last_id;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Opcode bit 2 marks legal ops, bit 3 separates arithmetic from logic.
    assign legal     = alu_opcode[2];
    assign arith     = alu_opcode[3];
    assign alu_en    = (state == ISSUE) && legal;
    assign rsp_valid = (state == RESP);
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_cin    <= 1'b0;
            alu_opcode <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_out    <= 8'd0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= grant1 ? req1_a      : req0_a;
                alu_b      <= grant1 ? req1_b      : req0_b;
                alu_cin    <= grant1 ? req1_cin    : req0_cin;
                alu_opcode <= grant1 ? req1_opcode : req0_opcode;
                rsp_id     <= grant1;
                last_id    <= grant1;
            end
            if (state == ISSUE) begin
                rsp_err <= !legal;
                if (legal) begin
                    rsp_out  <= alu_out;
                    rsp_cout <= arith && alu_cout;
                    rsp_zero <= (alu_out == 8'd0);
                end else begin
                    rsp_out  <= 8'd0;
                    rsp_cout <= 1'b0;
                    rsp_zero <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_err  <= '0;
        end else if (rsp_fire) begin
            if (!rsp_id && (stat_ops0 != '1)) stat_ops0 <= stat_ops0 + 1'b1;
            if (rsp_id && (stat_ops1 != '1))  stat_ops1 <= stat_ops1 + 1'b1;
            if (rsp_err && (stat_err != '1))  stat_err  <= stat_err + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Randomised and directed bench for alu_arb_ctrl with a behavioural ALU and a response scoreboard.
// Build with ALU_ARB_STATS_EN defined to also check the statistics counters.
module tb_alu_arb_ctrl;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } req_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_opcode = '0, req1_opcode = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_cin, alu_en, alu_cout;
    logic [3:0] alu_opcode;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, rsp_zero, rsp_err;
    logic [7:0] rsp_out;
    logic [1:0] fsm_state;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_ops0, stat_ops1, stat_err;
    logic [15:0] m_ops0, m_ops1, m_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: {id, err, zero, cout, out} per accepted op, oldest first.
    logic [11:0] exp_q[$];
    logic        busy;
    int          age;
    logic        last_id;
    req_t        last_op;

    always #5 clk = ~clk;

    alu_arb_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_en(alu_en), .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
`ifdef ALU_ARB_STATS_EN
        .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_err(stat_err),
`endif
        .fsm_state(fsm_state)
    );

    // Behavioural ALU; logic ops and illegal codes deliberately drive a nonzero-ish carry.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        case (op)
            4'b1111: return {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'b1110: return {1'b0, a} - {1'b0, b} - {8'd0, cin};
            4'b1101: return {1'b0, a} + 9'd1;
            4'b1100: return {1'b0, a} - 9'd1;
            4'b0111: return {^a, a & b};
            4'b0110: return {^a, a | b};
            4'b0101: return {^a, ~a};
            4'b0100: return {^a, a ^ b};
            default: return {1'b1, a ^ 8'h5A};
        endcase
    endfunction

    always_comb begin
        {alu_cout, alu_out} = alu_en ? alu_fn(alu_opcode, alu_a, alu_b, alu_cin) : 9'h1A5;
    end

    function automatic logic [11:0] model_rsp(input req_t r, input logic id);
        logic [8:0] res;
        logic [7:0] out;
        logic       cout, err;
        res = alu_fn(r.op, r.a, r.b, r.cin);
        err = (r.op[2] == 1'b0);
        out = err ? 8'd0 : res[7:0];
        cout = (!err && r.op[3]) ? res[8] : 1'b0;
        return {id, err, (out == 8'd0), cout, out};
    endfunction

    function automatic req_t mk(input logic v, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic cin);
        req_t r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.cin = cin;
        return r;
    endfunction

    function automatic req_t rand_req(input int pct_valid);
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                         : {1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
        return mk(($urandom_range(0, 99) < pct_valid), op, 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check before the rising edge, advance the model.
    task automatic step(input req_t r0, input req_t r1, input logic rr);
        logic        g0, g1, winner, fire;
        logic [11:0] e;
        req_t        sel;
        req0_valid = r0.v; req0_opcode = r0.op; req0_a = r0.a; req0_b = r0.b; req0_cin = r0.cin;
        req1_valid = r1.v; req1_opcode = r1.op; req1_a = r1.a; req1_b = r1.b; req1_cin = r1.cin;
        rsp_ready = rr;
        #1;
        winner = (r0.v && r1.v) ? !last_id : r1.v;
        g0 = !busy && (r0.v || r1.v) && (winner == 1'b0);
        g1 = !busy && (r0.v || r1.v) && (winner == 1'b1);
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        check("both_ready", 32'(req0_ready && req1_ready), 32'd0);
        check("alu_en", 32'(alu_en), 32'(busy && age == 1 && last_op.op[2]));
        check("rsp_valid", 32'(rsp_valid), 32'(busy && age >= 2));
        check("alu_regs", {13'd0, alu_opcode, alu_a, alu_b, alu_cin},
              {13'd0, last_op.op, last_op.a, last_op.b, last_op.cin});
        if (busy && age >= 2) begin
            e = exp_q[0];
            check("rsp_id", 32'(rsp_id), 32'(e[11]));
            check("rsp_err", 32'(rsp_err), 32'(e[10]));
            check("rsp_zero", 32'(rsp_zero), 32'(e[9]));
            check("rsp_cout", 32'(rsp_cout), 32'(e[8]));
            check("rsp_out", 32'(rsp_out), 32'(e[7:0]));
        end
`ifdef ALU_ARB_STATS_EN
        check("stat_ops0", 32'(stat_ops0), 32'(m_ops0));
        check("stat_ops1", 32'(stat_ops1), 32'(m_ops1));
        check("stat_err", 32'(stat_err), 32'(m_err));
`endif
        fire = busy && age >= 2 && rr;
        @(posedge clk);
        if (busy) begin
            if (fire) begin
`ifdef ALU_ARB_STATS_EN
                if (!exp_q[0][11] && m_ops0 != 16'hFFFF) m_ops0++;
                if (exp_q[0][11] && m_ops1 != 16'hFFFF) m_ops1++;
                if (exp_q[0][10] && m_err != 16'hFFFF) m_err++;
`endif
                void'(exp_q.pop_front());
                busy = 1'b0;
            end else begin
                age++;
            end
        end else if (g0 || g1) begin
            sel = g1 ? r1 : r0;
            last_op = sel;
            last_id = g1;
            exp_q.push_back(model_rsp(sel, g1));
            busy = 1'b1;
            age = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        busy = 1'b0;
        age = 0;
        last_id = 1'b1;
        last_op = '0;
`ifdef ALU_ARB_STATS_EN
        m_ops0 = '0; m_ops1 = '0; m_err = '0;
        check("rst_stats", 32'({stat_ops0, stat_ops1} | {16'd0, stat_err}), 32'd0);
`endif
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_rsp", {20'd0, rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_zero}, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_alu", {12'd0, alu_en, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Add with carry out, then a logic op from requester 1 and an increment wrap.
        step(mk(1, 4'b1111, 8'hFF, 8'h01, 1'b0), mk(0, 0, 0, 0, 0), 1'b1);
        idle(3);
        step(mk(0, 0, 0, 0, 0), mk(1, 4'b0111, 8'hF0, 8'h3C, 1'b0), 1'b1);
        idle(3);
        step(mk(1, 4'b1101, 8'hFF, 8'h00, 1'b0), mk(0, 0, 0, 0, 0), 1'b1);
        idle(3);
        step(mk(1, 4'b1100, 8'h00, 8'h00, 1'b0), mk(0, 0, 0, 0, 0), 1'b1);
        idle(3);

        // Both requesters hold valid: grants alternate, one op per three cycles.
        for (int i = 0; i < 12; i++) step(rand_req(100), rand_req(100), 1'b1);
        idle(3);

        // Illegal opcode.
        step(mk(1, 4'b0011, 8'h55, 8'h00, 1'b0), mk(0, 0, 0, 0, 0), 1'b1);
        idle(3);

        // Backpressure with both requesters waiting.
        step(mk(1, 4'b1110, 8'h10, 8'h03, 1'b1), mk(0, 0, 0, 0, 0), 1'b1);
        for (int i = 0; i < 6; i++) step(rand_req(100), rand_req(100), 1'b0);
        step(rand_req(100), rand_req(100), 1'b1);
        idle(4);

        // Reset while the op is in ISSUE: it vanishes and requester 0 wins the next contest.
        step(mk(0, 0, 0, 0, 0), mk(1, 4'b1111, 8'h12, 8'h34, 1'b0), 1'b1);
        do_reset();
        check("rst_midop_en", 32'(alu_en), 32'd0);
        step(rand_req(100), rand_req(100), 1'b1);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            else step(rand_req(60), rand_req(60), 1'($urandom_range(0, 99) < 70));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
